out_port_ctrl: RTL and testbench

- Output-port peripheral for the `out` instruction; the counterpart of the InPort path used by `in`.
- The control step that asserts OutPortin captures the datapath bus word into a holding register (OutPort_out).
- The same strobe also pushes the word into a small FIFO, which drains to an external device over a valid/ready handshake.
- Sits beside the datapath; its write side is driven by the same OutPortin/BusMuxOut signals the control unit already produces.

---
 rtl/out_port_ctrl.sv | 88 ++++++++
 tb/tb_out_port_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_port_ctrl.sv
// Output-port peripheral for the `out` instruction: holding register plus small FIFO.
// A write reaches tx_valid one cycle later; tx_ready=0 backpressures, and a write into a full FIFO is dropped and sets overflow.
module out_port_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  OutPortin,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  output logic [DATA_WIDTH-1:0] OutPort_out,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  full,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_out_port;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_strobe_d;
  logic                  r_overflow;

  logic w_write;
  logic w_full;
  logic w_valid;
  logic w_pop;
  logic w_push;

  // The strobe is a level from the control unit; only its first cycle counts as a write.
  assign w_write = OutPortin & ~r_strobe_d;
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & tx_ready;
  assign w_push  = w_write & (~w_full | w_pop);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_out_port <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_strobe_d <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_strobe_d <= OutPortin;
      if (w_write) begin
        r_out_port <= BusMuxOut;
      end
      if (w_write && !w_push) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= BusMuxOut;
    end
  end

  assign OutPort_out = r_out_port;
  assign tx_data     = r_mem[r_rd_ptr];
  assign tx_valid    = w_valid;
  assign full        = w_full;
  assign count       = r_count;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_out_port_ctrl.sv
// Bench for out_port_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_out_port_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          OutPortin;
  logic [DW-1:0] BusMuxOut;
  logic [DW-1:0] OutPort_out;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          full;
  logic [CNT_W-1:0] count;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  // Reference model: plain queue of accepted words.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_out;
  logic          m_ovf;
  logic          m_prev;

  out_port_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .OutPortin(OutPortin), .BusMuxOut(BusMuxOut),
    .OutPort_out(OutPort_out), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .full(full), .count(count), .overflow(overflow)
  );

  always #5 Clock = ~Clock;

  task automatic model_reset();
    m_q.delete();
    m_out  = '0;
    m_ovf  = 1'b0;
    m_prev = 1'b0;
  endtask

  // Advance the model with the inputs present at the coming edge, then pass the edge.
  task automatic tick();
    logic wr, pop, push;
    logic [DW-1:0] d;
    wr   = OutPortin && !m_prev;
    pop  = (m_q.size() != 0) && tx_ready;
    push = wr && ((m_q.size() < DEPTH) || pop);
    if (wr) m_out = BusMuxOut;
    if (wr && !push) m_ovf = 1'b1;
    if (pop) d = m_q.pop_front();
    if (push) m_q.push_back(BusMuxOut);
    m_prev = OutPortin;
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse(input logic [DW-1:0] d);
    OutPortin = 1'b1;
    BusMuxOut = d;
    tick();
    OutPortin = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    #2;
    Reset = 1'b1;
    model_reset();
    #2;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (count !== 3'd0 || tx_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 || OutPort_out !== '0) begin
      errors++;
      $display("FAIL reset_state: count=%0d tx_valid=%b full=%b overflow=%b out=%h, required 0/0/0/0/0",
               count, tx_valid, full, overflow, OutPort_out);
    end
  endtask

  task automatic test_reset_midstream();
    pulse(32'h11); pulse(32'h22); pulse(32'h33);
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL midstream_prefill: count=%0d required 3", count);
    end
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (count !== 3'd0 || tx_valid !== 1'b0 || OutPort_out !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d tx_valid=%b out=%h overflow=%b, required 0/0/0/0",
               count, tx_valid, OutPort_out, overflow);
    end
    #2;
    Reset = 1'b0;
  endtask

  task automatic test_single_write();
    tx_ready  = 1'b0;
    BusMuxOut = 32'h0000_00A5;
    OutPortin = 1'b1;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pre_valid: tx_valid=%b required 0", tx_valid);
    end
    tick();
    checks++;
    if (OutPort_out !== 32'hA5 || tx_valid !== 1'b1 || count !== 3'd1) begin
      errors++;
      $display("FAIL single_first_edge: out=%h tx_valid=%b count=%0d, required a5/1/1",
               OutPort_out, tx_valid, count);
    end
    BusMuxOut = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (count !== 3'd1 || tx_data !== 32'hA5 || tx_valid !== 1'b1 || OutPort_out !== 32'hA5) begin
        errors++;
        $display("FAIL single_held_strobe: count=%0d tx_data=%h tx_valid=%b out=%h, required 1/a5/1/a5",
                 count, tx_data, tx_valid, OutPort_out);
      end
    end
    OutPortin = 1'b0;
    tx_ready  = 1'b1;
    tick();
    tx_ready  = 1'b0;
    checks++;
    if (count !== 3'd0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: count=%0d tx_valid=%b, required 0/0", count, tx_valid);
    end
    // Ready while empty must not underflow.
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_ready: count=%0d tx_valid=%b, required 0/0", count, tx_valid);
    end
  endtask

  task automatic test_fill_overflow();
    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) pulse(DW'(i));
    checks++;
    if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill: full=%b count=%0d overflow=%b, required 1/4/0", full, count, overflow);
    end
    pulse(32'd5);
    checks++;
    if (OutPort_out !== 32'd5 || overflow !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL overflow: out=%0d overflow=%b count=%0d, required 5/1/4", OutPort_out, overflow, count);
    end
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== DW'(i)) begin
        errors++;
        $display("FAIL drain_%0d: tx_valid=%b tx_data=%0d, required 1/%0d", i, tx_valid, tx_data, i);
      end
      tick();
    end
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drain_end: tx_valid=%b overflow=%b, required 0/1 (sticky)", tx_valid, overflow);
    end
    do_reset();
  endtask

  task automatic test_push_pop_full();
    tx_ready = 1'b0;
    for (int i = 10; i <= 13; i++) pulse(DW'(i));
    tx_ready  = 1'b1;
    OutPortin = 1'b1;
    BusMuxOut = 32'd14;
    tick();
    OutPortin = 1'b0;
    checks++;
    if (count !== 3'd4 || overflow !== 1'b0 || full !== 1'b1 || OutPort_out !== 32'd14) begin
      errors++;
      $display("FAIL pushpop_full: count=%0d overflow=%b full=%b out=%0d, required 4/0/1/14",
               count, overflow, full, OutPort_out);
    end
    for (int i = 11; i <= 14; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== DW'(i)) begin
        errors++;
        $display("FAIL pushpop_order: tx_valid=%b tx_data=%0d, required 1/%0d", tx_valid, tx_data, i);
      end
      tick();
    end
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL pushpop_empty: tx_valid=%b count=%0d, required 0/0", tx_valid, count);
    end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int rcvd = 0;
    int cyc  = 0;
    while (rcvd < 10 && cyc < 200) begin
      OutPortin = (cyc % 3 == 0) && (sent < 10);
      BusMuxOut = DW'(100 + sent);
      tx_ready  = (cyc % 4) < 2;
      if (tx_valid && tx_ready) begin
        checks++;
        if (tx_data !== DW'(100 + rcvd)) begin
          errors++;
          $display("FAIL wrap_order: tx_data=%0d required %0d", tx_data, 100 + rcvd);
        end
        rcvd++;
      end
      if (OutPortin) sent++;
      tick();
      cyc++;
    end
    OutPortin = 1'b0;
    tx_ready  = 1'b0;
    checks++;
    if (rcvd != 10 || overflow !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL wrap_done: received=%0d overflow=%b count=%0d, required 10/0/0", rcvd, overflow, count);
    end
  endtask

  task automatic test_random();
    tick();
    for (int i = 0; i < 400; i++) begin
      OutPortin = ($urandom_range(0, 2) == 0);
      BusMuxOut = $urandom;
      tx_ready  = ($urandom_range(0, 2) != 0);
      if (i % 5 == 0) tx_ready = 1'b0;
      tick();
      checks++;
      if (count !== CNT_W'(m_q.size()) || tx_valid !== (m_q.size() != 0) ||
          full !== (m_q.size() == DEPTH) || overflow !== m_ovf || OutPort_out !== m_out ||
          (m_q.size() != 0 && tx_data !== m_q[0])) begin
        errors++;
        $display("FAIL random_%0d: count=%0d valid=%b full=%b ovf=%b out=%h data=%h, required count=%0d ovf=%b out=%h head=%h",
                 i, count, tx_valid, full, overflow, OutPort_out, tx_data,
                 m_q.size(), m_ovf, m_out, (m_q.size() != 0) ? m_q[0] : '0);
      end
    end
    OutPortin = 1'b0;
    tx_ready  = 1'b0;
  endtask

  initial begin
    Reset     = 1'b1;
    OutPortin = 1'b0;
    BusMuxOut = '0;
    tx_ready  = 1'b0;
    model_reset();
    #1;
    test_reset();
    #2;
    Reset = 1'b0;
    tick();
    test_reset_midstream();
    tick();
    test_single_write();
    test_fill_overflow();
    test_push_pop_full();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
